// File: rtl/mmio_flush_cpl_arb.sv
// mmio_flush_cpl_arb: shares one TX completion stream between AFU traffic and generated MMIO completions.
// AFU packets are discarded whole while blocking; each pending MMIO read gets a generated 3DW CplD.
module mmio_flush_cpl_arb #(
    parameter int DATA_WIDTH = 512,
    parameter int TAG_WIDTH  = 10,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_afu_tvalid,
    output logic                  o_afu_tready,
    input  logic [DATA_WIDTH-1:0] i_afu_tdata,
    input  logic                  i_afu_tlast,
    output logic                  o_tx_tvalid,
    input  logic                  i_tx_tready,
    output logic [DATA_WIDTH-1:0] o_tx_tdata,
    output logic                  o_tx_tlast,
    output logic                  o_tx_gen,
    input  logic                  i_blocking_traffic,
    input  logic                  i_pend_valid,
    input  logic [TAG_WIDTH-1:0]  i_pend_tag,
    input  logic [9:0]            i_pend_len,
    input  logic [15:0]           i_pend_req_id,
    input  logic [6:0]            i_pend_addr_lo,
    input  logic [15:0]           i_cpl_id,
    output logic                  o_pend_ack,
    output logic [CNT_WIDTH-1:0]  o_drop_pkt_cnt,
    output logic [CNT_WIDTH-1:0]  o_gen_cpl_cnt
);
    typedef enum logic [1:0] {IDLE, AFU, GEN} state_t;

    state_t               state_q;
    logic                 afu_mid_q, disc_q, last_gen_q, ack_q;
    logic [95:0]          hdr_q;
    logic [CNT_WIDTH-1:0] drop_q, gen_q;

    logic        cur_disc, afu_req, pend_req, grant_afu, grant_gen, afu_own, afu_acc, tx_hs;
    logic [9:0]  tag10;
    logic [95:0] hdr_d;

    always_comb begin
        tag10        = 10'(i_pend_tag);
        // Once AFU owns the output its packet can no longer become a discard, even before the SOP is taken.
        cur_disc     = (state_q != AFU) && (afu_mid_q ? disc_q : i_blocking_traffic);
        afu_req      = i_afu_tvalid && !cur_disc;
        pend_req     = i_pend_valid && !ack_q;
        grant_afu    = (state_q == IDLE) && afu_req && (!pend_req || last_gen_q);
        grant_gen    = (state_q == IDLE) && pend_req && (!afu_req || !last_gen_q);
        afu_own      = rst_n && ((state_q == AFU) || grant_afu);
        o_tx_tvalid  = (state_q == GEN) || (afu_own && i_afu_tvalid);
        o_tx_tdata   = (state_q == GEN) ? {{(DATA_WIDTH-96){1'b1}}, hdr_q} : i_afu_tdata;
        o_tx_tlast   = (state_q == GEN) || (afu_own && i_afu_tlast);
        o_tx_gen     = (state_q == GEN);
        o_afu_tready = rst_n && (cur_disc || (afu_own && i_tx_tready));
        afu_acc      = i_afu_tvalid && o_afu_tready;
        tx_hs        = (state_q == GEN) && i_tx_tready;
        hdr_d        = {i_pend_req_id, tag10[7:0], 1'b0, i_pend_addr_lo,
                        i_cpl_id, 3'b000, 1'b0, {i_pend_len, 2'b00},
                        3'b010, 5'b01010, tag10[9], 3'b000, tag10[8], 9'b0, i_pend_len};
        o_pend_ack     = ack_q;
        o_drop_pkt_cnt = drop_q;
        o_gen_cpl_cnt  = gen_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            afu_mid_q  <= 1'b0;
            disc_q     <= 1'b0;
            last_gen_q <= 1'b0;
            ack_q      <= 1'b0;
            hdr_q      <= '0;
            drop_q     <= '0;
            gen_q      <= '0;
        end else begin
            state_q    <= (state_q == GEN) ? (i_tx_tready ? IDLE : GEN) :
                          grant_gen ? GEN :
                          (afu_own && !(afu_acc && i_afu_tlast)) ? AFU : IDLE;
            afu_mid_q  <= afu_acc ? !i_afu_tlast : afu_mid_q;
            disc_q     <= (afu_acc && !afu_mid_q) ? cur_disc : disc_q;
            last_gen_q <= grant_gen ? 1'b1 : grant_afu ? 1'b0 : last_gen_q;
            ack_q      <= tx_hs;
            hdr_q      <= grant_gen ? hdr_d : hdr_q;
            if (afu_acc && cur_disc && i_afu_tlast && drop_q != '1)
                drop_q <= drop_q + 1'b1;
            if (tx_hs && gen_q != '1)
                gen_q <= gen_q + 1'b1;
        end
    end
endmodule
